alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one external combinational ALU; one op in flight.
// Latency: accept at T, EXEC at T+1, response valid from T+2; issue interval >= 3.
// Backpressure: req_ready only in IDLE; response held in RESP until owner's rsp_ready.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready [1:0]  per-port request handshake
//   req_a/req_b [31:0]         {port1, port0} 16-bit operands
//   req_op [5:0]               {port1, port0} 3-bit ALU codes
//   rsp_valid/rsp_ready [1:0]  per-port response handshake (rsp_valid one-hot)
//   rsp_data/carry/zero        registered ALU result and flags
//   alu_a/alu_b/alu_code       operands to the shared ALU (from captured registers)
//   alu_out/carry/zero         combinational ALU result and flags
module alu_arbiter #(
    parameter int FIXED_PRI = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [5:0]  req_op,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_code,
    input  logic [15:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    logic        owner;       // port whose operation is in flight
    logic        last;        // port served by the most recent accept
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [2:0]  op_q;
    logic [1:0]  grant;
    logic        win;

    // Winner selection. last==1 means port 1 was served last, so port 0 is
    // preferred on a tie. Gated by rst_n so req_ready drops the moment reset asserts.
    always_comb begin
        grant = 2'b00;
        win   = 1'b0;
        if (rst_n && state == IDLE) begin
            case (req_valid)
                2'b01: grant = 2'b01;
                2'b10: begin
                    grant = 2'b10;
                    win   = 1'b1;
                end
                2'b11: begin
                    if (FIXED_PRI != 0 || last) begin
                        grant = 2'b01;
                    end else begin
                        grant = 2'b10;
                        win   = 1'b1;
                    end
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_code  = op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            op_q      <= 3'b000;
            rsp_valid <= 2'b00;
            rsp_data  <= 16'h0000;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        a_q   <= win ? req_a[31:16] : req_a[15:0];
                        b_q   <= win ? req_b[31:16] : req_b[15:0];
                        op_q  <= win ? req_op[5:3]  : req_op[2:0];
                        owner <= win;
                        last  <= win;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_carry <= alu_carry;
                    rsp_zero  <= alu_zero;
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    // Only the owner's rsp_ready completes the response.
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
